// File: rtl/add32.sv
// 32-bit two-level carry-lookahead adder with combinational and registered outputs.
// Carry-in is tied low; registered copies use a synchronous active-high reset.

module add32_cla4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_g,
   output logic       o_p
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [3:0] w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Internal carries fully expanded so no bit waits on its neighbour.
   assign w_c[0] = i_cin;
   assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_cin);

   assign o_sum = w_p ^ w_c;
   assign o_g   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign o_p   = &w_p;

endmodule

module add32_lcu8 (
   input  logic [7:0] i_g,
   input  logic [7:0] i_p,
   input  logic       i_cin,
   output logic [8:0] o_c
);

   logic w_acc;
   logic w_term;

   // Each group carry is an OR of generate terms gated by the propagates above them.
   always_comb begin
      o_c    = '0;
      w_acc  = 1'b0;
      w_term = 1'b0;
      o_c[0] = i_cin;
      for (int unsigned j = 1; j <= 8; j++) begin
         w_acc = i_cin;
         for (int unsigned m = 0; m < j; m++) begin
            w_acc = w_acc & i_p[m];
         end
         for (int unsigned k = 0; k < j; k++) begin
            w_term = i_g[k];
            for (int unsigned m = k + 1; m < j; m++) begin
               w_term = w_term & i_p[m];
            end
            w_acc = w_acc | w_term;
         end
         o_c[j] = w_acc;
      end
   end

endmodule

module add32 (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y,
   output logic        cout,
   output logic        ovf,
   output logic [31:0] y_q,
   output logic        cout_q,
   output logic        ovf_q
);

   logic [7:0]  w_gg;
   logic [7:0]  w_gp;
   logic [8:0]  w_c;
   logic [31:0] w_sum;

   for (genvar gi = 0; gi < 8; gi++) begin : g_grp
      add32_cla4 u_cla4 (
         .i_a   (a[gi*4 +: 4]),
         .i_b   (b[gi*4 +: 4]),
         .i_cin (w_c[gi]),
         .o_sum (w_sum[gi*4 +: 4]),
         .o_g   (w_gg[gi]),
         .o_p   (w_gp[gi])
      );
   end

   add32_lcu8 u_lcu (
      .i_g   (w_gg),
      .i_p   (w_gp),
      .i_cin (1'b0),
      .o_c   (w_c)
   );

   assign y    = w_sum;
   assign cout = w_c[8];
   assign ovf  = (a[31] == b[31]) && (w_sum[31] != a[31]);

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         y_q    <= y;
         cout_q <= cout;
         ovf_q  <= ovf;
      end
   end

endmodule

// File: tb/tb_add32.sv
// Scoreboard bench for add32: driver pushes expected registered results,
// a monitor pops and compares one cycle later; combinational outputs checked inline.

module tb_add32;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] y;
   logic        cout;
   logic        ovf;
   logic [31:0] y_q;
   logic        cout_q;
   logic        ovf_q;

   typedef struct packed {
      logic [31:0] y;
      logic        c;
      logic        o;
   } res_t;

   res_t        q[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   bit          clk_run  = 1'b0;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   add32 dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .y      (y),
      .cout   (cout),
      .ovf    (ovf),
      .y_q    (y_q),
      .cout_q (cout_q),
      .ovf_q  (ovf_q)
   );

   initial begin
      clk = 1'b0;
      wait (clk_run);
      forever #5 clk = ~clk;
   end

   // Reference: wide unsigned sum for y/carry, wide signed sum range test for overflow.
   function automatic res_t model(logic [31:0] x, logic [31:0] z);
      longint unsigned us;
      longint          ss;
      res_t            r;
      us  = 64'(x) + 64'(z);
      ss  = 64'($signed(x)) + 64'($signed(z));
      r.y = us[31:0];
      r.c = us[32];
      r.o = (ss > SMAX) || (ss < SMIN);
      return r;
   endfunction

   task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (a=%h b=%h rst=%b t=%0t)", nm, act, exp, a, b, rst, $time);
      end
   endtask

   task automatic dir(input logic [31:0] x, input logic [31:0] z,
                      input logic [31:0] ey, input logic ec, input logic eo, input string tag);
      a = x;
      b = z;
      #1;
      check({tag, " y"},    {1'b0, y}, {1'b0, ey});
      check({tag, " cout"}, 33'(cout), 33'(ec));
      check({tag, " ovf"},  33'(ovf),  33'(eo));
   endtask

   task automatic drive(input logic [31:0] x, input logic [31:0] z, input logic r, input bit glitch);
      res_t e;
      if (glitch) begin
         a = $urandom;
         b = $urandom;
         #1;
      end
      a   = x;
      b   = z;
      rst = r;
      #1;
      e = model(x, z);
      check("comb y",    {1'b0, y}, {1'b0, e.y});
      check("comb cout", 33'(cout), 33'(e.c));
      check("comb ovf",  33'(ovf),  33'(e.o));
      if (r) e = '0;
      q.push_back(e);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] tbl [5];
      tbl[0] = 32'h0000_0000;
      tbl[1] = 32'h0000_0001;
      tbl[2] = 32'h7FFF_FFFF;
      tbl[3] = 32'h8000_0000;
      tbl[4] = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   // Monitor: registered outputs are valid just after every rising edge.
   initial begin
      res_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("reg y_q",    {1'b0, y_q}, {1'b0, e.y});
            check("reg cout_q", 33'(cout_q), 33'(e.c));
            check("reg ovf_q",  33'(ovf_q),  33'(e.o));
         end
      end
   end

   initial begin
      rst = 1'b1;
      a   = '0;
      b   = '0;
      #1;
      dir(32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, "1+1");
      dir(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, "min+min");
      dir(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, "max+max");
      dir(32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "min+max");
      dir(32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "max+min");
      dir(32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 1'b0, 1'b0, "noclk min+1");
      dir(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, "wrap");

      drive(32'h0, 32'h0, 1'b1, 1'b0);
      clk_run = 1'b1;
      @(negedge clk) drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      @(negedge clk) drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
      check("held cout", 33'(cout), 33'(1'b1));
      @(negedge clk) drive(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
      @(negedge clk) drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);

      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         drive(pick(), pick(), ($urandom_range(0, 19) == 0), bit'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      check("queue drained", 33'(q.size()), 33'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/add32.md
ADD32 -- requirements
Module: add32

Interface
REQ-001 The block SHALL have no parameters; the operand width SHALL be fixed at 32 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock for the registered outputs.
REQ-004 Port: rst  input  1  synchronous active-high reset; it SHALL be sampled only on the rising edge of clk.
REQ-005 Port: a  input  32  first operand, unsigned or two's complement.
REQ-006 Port: b  input  32  second operand, unsigned or two's complement.
REQ-007 Port: y  output  32  combinational sum, a+b mod 2^32.
REQ-008 Port: cout  output  1  combinational carry out of bit 31.
REQ-009 Port: ovf  output  1  combinational signed-overflow flag.
REQ-010 Port: y_q  output  32  y registered on clk.
REQ-011 Port: cout_q  output  1  cout registered on clk.
REQ-012 Port: ovf_q  output  1  ovf registered on clk.

Function
REQ-013 y SHALL equal (a+b)[31:0], combinational, with no clock needed.
REQ-014 cout SHALL equal bit 32 of the 33-bit unsigned sum {1'b0,a}+{1'b0,b}.
REQ-015 ovf SHALL be 1 iff a[31]==b[31] and y[31]!=a[31]; otherwise ovf SHALL be 0.
REQ-016 The carry-in SHALL be internally tied to 0; the block SHALL have no cin port.
REQ-017 The adder SHALL be a two-level carry-lookahead structure:
- eight 4-bit CLA groups, each producing per-bit generate (a&b) and propagate (a^b), group G/P and internal carries;
- a second-level lookahead unit SHALL compute the group carry-ins from group G/P;
- a behavioural "+" operator SHALL NOT be used for the datapath.
REQ-018 y, cout and ovf SHALL settle within a single combinational evaluation after any change of a or b.
REQ-019 y, cout and ovf SHALL be independent of clk and rst.
REQ-020 On each rising clk edge with rst=0, y_q, cout_q and ovf_q SHALL capture the current y, cout and ovf; the latency SHALL be 1 cycle.
REQ-021 Wrap-around: results SHALL wrap modulo 2^32, and the carry SHALL be reported only on cout and cout_q.
REQ-022 If a or b changes between clock edges, only the value present at the rising edge SHALL be captured.

Reset
REQ-023 On a rising clk edge with rst=1, y_q SHALL become 0x00000000, and cout_q and ovf_q SHALL become 0.
REQ-024 Reset SHALL take priority over capture when both apply at the same edge.
REQ-025 Asserting reset mid-operation SHALL clear the registered outputs at the next edge and SHALL NOT affect y, cout or ovf.
REQ-026 Registered outputs SHALL remain at their reset values while rst=1.
REQ-027 After rst is released, the first capture SHALL occur on the first rising edge at which rst is sampled 0.

Verification
REQ-028 a=0x00000001, b=0x00000001 -> y=0x00000002, cout=0, ovf=0.
REQ-029 a=0x80000000, b=0x80000000 -> y=0x00000000, cout=1, ovf=1.
REQ-030 a=0x7FFFFFFF, b=0x7FFFFFFF -> y=0xFFFFFFFE, cout=0, ovf=1.
REQ-031 Operands 0x80000000 and 0x7FFFFFFF, in both orders -> y=0xFFFFFFFF, cout=0, ovf=0.
REQ-032 a=0x80000000, b=0x00000001 -> y=0x80000001, cout=0, ovf=0, checked with no clock running.
REQ-033 Registered path: rst=1 for one edge -> y_q=0; then rst=0, a=0xFFFFFFFF, b=0x00000001 -> after one edge y_q=0x00000000, cout_q=1, ovf_q=0; then assert rst at the next edge while inputs are held -> y_q=0, cout_q=0, and cout stays 1.
